// File: rtl/imm_ext.sv
// Immediate extender for the MIPS datapath. Provides a combinational result
// and a registered copy with a valid flag and opcode echo.
module imm_ext (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] imm,
    input  logic [1:0]  EOp,
    input  logic        in_valid,
    output logic [31:0] ext,
    output logic [31:0] ext_q,
    output logic        out_valid,
    output logic [1:0]  eop_q
);

    typedef enum logic [1:0] {
        EOP_SIGN   = 2'b00,
        EOP_ZERO   = 2'b01,
        EOP_UPPER  = 2'b10,
        EOP_BRANCH = 2'b11
    } eop_e;

    eop_e        eop_sel;
    logic [31:0] ext_d;
    logic [1:0]  eop_d;
    logic        valid_q;

    assign eop_sel = eop_e'(EOp);

    always_comb begin
        ext_d = '0;
        case (eop_sel)
            EOP_SIGN:   ext_d = {{16{imm[15]}}, imm};
            EOP_ZERO:   ext_d = {16'h0000, imm};
            EOP_UPPER:  ext_d = {imm, 16'h0000};
            EOP_BRANCH: ext_d = {{14{imm[15]}}, imm, 2'b00};
            default:    ext_d = '0;
        endcase
    end

    // Payload only advances on a capture so ext_q/eop_q hold while idle.
    always_comb begin
        eop_d = eop_q;
        if (in_valid) begin
            eop_d = EOp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q   <= '0;
            eop_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            eop_q   <= eop_d;
            if (in_valid) begin
                ext_q <= ext_d;
            end
        end
    end

    assign ext       = ext_d;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_imm_ext.sv
// Self-checking bench for imm_ext: combinational sweeps plus a scoreboard
// of expected {eop, ext} pairs for the registered path.
module tb_imm_ext;

    logic        clk;
    logic        reset;
    logic [15:0] imm;
    logic [1:0]  EOp;
    logic        in_valid;
    logic [31:0] ext;
    logic [31:0] ext_q;
    logic        out_valid;
    logic [1:0]  eop_q;

    int total;
    int bad;
    logic [33:0] sb[$];
    logic [33:0] exp_pair;
    logic [31:0] held_ext;
    logic [1:0]  held_eop;

    imm_ext dut (
        .clk       (clk),
        .reset     (reset),
        .imm       (imm),
        .EOp       (EOp),
        .in_valid  (in_valid),
        .ext       (ext),
        .ext_q     (ext_q),
        .out_valid (out_valid),
        .eop_q     (eop_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] v, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'd0:    r = 32'($signed(v));
            2'd1:    r = 32'(v);
            2'd2:    r = 32'(v) << 16;
            default: r = 32'($signed(v)) << 2;
        endcase
        return r;
    endfunction

    // Drives one cycle of stimulus, records the expected capture, and returns
    // 1 time unit after the rising edge with the inputs still applied.
    task automatic cycle(input logic rst, input logic v, input logic [15:0] im, input logic [1:0] op);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        imm      = im;
        EOp      = op;
        if (v && !rst) sb.push_back({op, model(im, op)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 16'hABCD, 2'd3);
        cycle(1'b1, 1'b0, 16'hABCD, 2'd3);
        total++;
        if (ext_q !== 32'h0) begin bad++; $display("FAIL reset_ext_q: got %h want %h", ext_q, 32'h0); end
        total++;
        if (eop_q !== 2'b00) begin bad++; $display("FAIL reset_eop_q: got %b want %b", eop_q, 2'b00); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want %b", out_valid, 1'b0); end
        total++;
        if (ext !== 32'hFFFEAF34) begin bad++; $display("FAIL reset_ext_comb: got %h want %h", ext, 32'hFFFEAF34); end
    endtask

    task automatic test_comb_sweep();
        logic [15:0] ims [2];
        logic [31:0] want [2][4];
        ims[0] = 16'h8000;
        ims[1] = 16'h7FFF;
        want[0][0] = 32'hFFFF8000; want[0][1] = 32'h00008000;
        want[0][2] = 32'h80000000; want[0][3] = 32'hFFFE0000;
        want[1][0] = 32'h00007FFF; want[1][1] = 32'h00007FFF;
        want[1][2] = 32'h7FFF0000; want[1][3] = 32'h0001FFFC;
        cycle(1'b0, 1'b0, 16'h0000, 2'd0);
        held_ext = ext_q;
        held_eop = eop_q;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                imm = ims[i];
                EOp = 2'(j);
                #1;
                total++;
                if (ext !== want[i][j]) begin
                    bad++;
                    $display("FAIL comb_sweep imm=%h op=%0d: got %h want %h", ims[i], j, ext, want[i][j]);
                end
                total++;
                if (ext !== model(ims[i], 2'(j))) begin
                    bad++;
                    $display("FAIL comb_model imm=%h op=%0d: got %h want %h", ims[i], j, ext, model(ims[i], 2'(j)));
                end
            end
        end
        total++;
        if (ext_q !== held_ext || eop_q !== held_eop) begin
            bad++;
            $display("FAIL comb_sweep_hold: got %h/%b want %h/%b", ext_q, eop_q, held_ext, held_eop);
        end
    endtask

    task automatic test_latency();
        cycle(1'b0, 1'b1, 16'h1234, 2'b10);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want %b", out_valid, 1'b1); end
        total++;
        if (ext_q !== 32'h12340000 || eop_q !== 2'b10) begin
            bad++;
            $display("FAIL lat_data: got %h/%b want %h/%b", ext_q, eop_q, 32'h12340000, 2'b10);
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL lat_sb_empty: got %0d want %0d", 0, 1);
        end else begin
            exp_pair = sb.pop_front();
            if ({eop_q, ext_q} !== exp_pair) begin
                bad++;
                $display("FAIL lat_sb: got %h want %h", {eop_q, ext_q}, exp_pair);
            end
        end
        cycle(1'b0, 1'b0, 16'h5555, 2'b01);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drop_valid: got %b want %b", out_valid, 1'b0); end
        total++;
        if (ext_q !== 32'h12340000 || eop_q !== 2'b10) begin
            bad++;
            $display("FAIL lat_hold: got %h/%b want %h/%b", ext_q, eop_q, 32'h12340000, 2'b10);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [2];
        want[0] = 32'hFFFFFFFF;
        want[1] = 32'h0000FFFF;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 16'hFFFF, 2'(k));
            total++;
            if (out_valid !== 1'b1 || ext_q !== want[k]) begin
                bad++;
                $display("FAIL b2b_%0d: got %b/%h want %b/%h", k, out_valid, ext_q, 1'b1, want[k]);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL b2b_sb_empty_%0d: got %0d want %0d", k, 0, 1);
            end else begin
                exp_pair = sb.pop_front();
                if ({eop_q, ext_q} !== exp_pair) begin
                    bad++;
                    $display("FAIL b2b_sb_%0d: got %h want %h", k, {eop_q, ext_q}, exp_pair);
                end
            end
        end
    endtask

    task automatic test_reset_priority();
        cycle(1'b0, 1'b1, 16'h8001, 2'b11);
        if (sb.size() != 0) exp_pair = sb.pop_front();
        total++;
        if ({eop_q, ext_q} !== exp_pair || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rp_preload: got %h/%b want %h/%b", {eop_q, ext_q}, out_valid, exp_pair, 1'b1);
        end
        cycle(1'b1, 1'b1, 16'h8000, 2'b11);
        total++;
        if (ext_q !== 32'h0 || eop_q !== 2'b00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rp_regs: got %h/%b/%b want %h/%b/%b", ext_q, eop_q, out_valid, 32'h0, 2'b00, 1'b0);
        end
        total++;
        if (ext !== 32'hFFFE0000) begin bad++; $display("FAIL rp_ext_comb: got %h want %h", ext, 32'hFFFE0000); end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 16'h0000, 2'(k));
            total++;
            if (ext !== 32'h0 || ext_q !== 32'h0) begin
                bad++;
                $display("FAIL zero_op%0d: got %h/%h want %h/%h", k, ext, ext_q, 32'h0, 32'h0);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL zero_sb_empty_%0d: got %0d want %0d", k, 0, 1);
            end else begin
                exp_pair = sb.pop_front();
                if ({eop_q, ext_q} !== exp_pair || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL zero_sb_%0d: got %h/%b want %h/%b", k, {eop_q, ext_q}, out_valid, exp_pair, 1'b1);
                end
            end
        end
    endtask

    task automatic test_idle_hold();
        cycle(1'b0, 1'b1, 16'hC3A5, 2'b00);
        if (sb.size() != 0) exp_pair = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 16'(16'h1111 * (k + 1)), 2'(k));
            total++;
            if ({eop_q, ext_q} !== exp_pair || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold_%0d: got %h/%b want %h/%b", k, {eop_q, ext_q}, out_valid, exp_pair, 1'b0);
            end
            total++;
            if (ext !== model(16'(16'h1111 * (k + 1)), 2'(k))) begin
                bad++;
                $display("FAIL idle_ext_%0d: got %h want %h", k, ext, model(16'(16'h1111 * (k + 1)), 2'(k)));
            end
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [15:0] im;
        logic [1:0]  op;
        logic [33:0] last;
        last = {eop_q, ext_q};
        for (int n = 0; n < 40; n++) begin
            v  = 1'($urandom_range(0, 1));
            im = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            cycle(1'b0, v, im, op);
            total++;
            if (out_valid !== v) begin
                bad++;
                $display("FAIL rnd_valid_%0d: got %b want %b", n, out_valid, v);
            end
            if (v) begin
                if (sb.size() != 0) last = sb.pop_front();
            end
            total++;
            if ({eop_q, ext_q} !== last) begin
                bad++;
                $display("FAIL rnd_data_%0d: got %h want %h", n, {eop_q, ext_q}, last);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        imm      = 16'h0;
        EOp      = 2'b00;
        exp_pair = '0;
        test_reset();
        test_comb_sweep();
        test_latency();
        test_back_to_back();
        test_reset_priority();
        test_zero();
        test_idle_hold();
        test_random();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d want %0d", sb.size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_ext.md
Name: imm_ext

Overview:
- Immediate extender for the MIPS datapath.
- Takes a 16-bit instruction immediate and a 2-bit extend opcode, and produces the 32-bit operand used by the ALU, load-upper and branch-offset paths.
- Provides a combinational result for the single-cycle datapath and a registered copy, with a valid flag, for pipelined use.

Parameters:
- None. All widths are fixed: immediate 16 bits, result 32 bits, opcode 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imm  input  16  instruction immediate field.
- EOp  input  2  extend opcode.
- in_valid  input  1  imm/EOp are valid this cycle; capture them into the output register.
- ext  output  32  combinational extended result of the current imm/EOp.
- ext_q  output  32  registered extended result.
- out_valid  output  1  ext_q holds the result of a captured request.
- eop_q  output  2  EOp that produced ext_q (echo for downstream decode).

Behaviour:
- Operation encoding, applied identically to ext (combinational) and to the value loaded into ext_q:
  - EOp=00, sign extend: {{16{imm[15]}}, imm}.
  - EOp=01, zero extend: {16'b0, imm}.
  - EOp=10, load upper: {imm, 16'b0}.
  - EOp=11, sign extend then shift left 2 (branch offset): {{14{imm[15]}}, imm, 2'b00}.
- ext is purely combinational:
  - No clock dependence; updates in the same time step as imm/EOp.
  - Unaffected by reset.
  - All four codes are defined, so ext is never X when inputs are known.
- Registered path:
  - 1-cycle latency.
  - On a rising clk with in_valid=1 and reset=0: ext_q <= ext, eop_q <= EOp, out_valid <= 1.
  - On a rising clk with in_valid=0 and reset=0: ext_q and eop_q hold their previous values; out_valid <= 0.
  - Back-to-back in_valid=1 is accepted every cycle. There is no backpressure and no internal queue.
- Reset:
  - reset=1 sampled at a rising clk clears ext_q to 32'h0000_0000, eop_q to 2'b00 and out_valid to 0.
  - Reset has priority over in_valid.
  - Asserting reset mid-stream discards the captured value.
- Boundary conditions:
  - imm=16'h7FFF (MSB 0): EOp 00 and 01 give equal results.
  - imm=16'h8000 (MSB 1): sign and zero extension differ.
  - EOp=11 discards imm sign bits beyond bit 31; there is no overflow indication.
  - imm=0 gives 0 for all opcodes.
- Changing EOp or imm while in_valid=0 alters ext only; ext_q is stable.

Test Plan:
- Opcode sweep, combinational, imm=16'h8000: EOp=00 -> ext=32'hFFFF8000; EOp=01 -> 32'h00008000; EOp=10 -> 32'h80000000; EOp=11 -> 32'hFFFE0000. Each checked 1 time unit after the input change, with no clock edge.
- Positive immediate, imm=16'h7FFF: EOp=00 -> 32'h00007FFF; 01 -> 32'h00007FFF; 10 -> 32'h7FFF0000; 11 -> 32'h0001FFFC.
- Registered latency: reset for 2 cycles, then in_valid=1, imm=16'h1234, EOp=10 for one cycle. Next edge -> ext_q=32'h12340000, eop_q=10, out_valid=1. Following edge with in_valid=0 -> out_valid=0, ext_q unchanged.
- Back-to-back capture: in_valid=1 on consecutive cycles with (16'hFFFF, 00) then (16'hFFFF, 01) -> ext_q=32'hFFFFFFFF, then 32'h0000FFFF; out_valid stays 1.
- Reset priority: reset=1 and in_valid=1 (imm=16'h8000, EOp=11) on the same edge -> ext_q=0, eop_q=00, out_valid=0, while ext=32'hFFFE0000 combinationally.
- Zero input: imm=0, all four EOp values -> ext=0 and, after capture, ext_q=0.
